// File: rtl/mem_access.sv
// MEM-stage load/store unit: serialises word/half/byte accesses over a byte-wide
// synchronous RAM port, extends load data and returns the writeback triple.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_enable,
    input  logic        store_enable,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  load_store_type,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    input  logic        rd_enable_in,
    input  logic        port_gnt,
    input  logic [7:0]  ram_din,
    output logic [31:0] ram_a,
    output logic [7:0]  ram_dout,
    output logic        ram_wr,
    output logic        port_own,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] rd_data_o,
    output logic [4:0]  rd_addr,
    output logic        rd_enable_o
);

    localparam logic [3:0] TYPE_LB  = 4'd0;
    localparam logic [3:0] TYPE_LH  = 4'd1;
    localparam logic [3:0] TYPE_LW  = 4'd2;
    localparam logic [3:0] TYPE_LBU = 4'd3;
    localparam logic [3:0] TYPE_LHU = 4'd4;
    localparam logic [3:0] TYPE_SB  = 4'd5;
    localparam logic [3:0] TYPE_SH  = 4'd6;
    localparam logic [3:0] TYPE_SW  = 4'd7;

    typedef enum logic [1:0] {StIdle, StAccess, StLast, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  type_q, type_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  rd_q, rd_d;
    logic        rd_en_q, rd_en_d;
    logic        is_load_q, is_load_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req;
    logic [1:0]  cap_idx;
    logic [1:0]  last_idx;
    logic [31:0] ext_data;

    // Index of the final byte: 0 for byte, 1 for halfword, 3 for word accesses.
    function automatic logic [1:0] last_byte(input logic [3:0] ty);
        case (ty)
            TYPE_LB, TYPE_LBU, TYPE_SB: last_byte = 2'd0;
            TYPE_LH, TYPE_LHU, TYPE_SH: last_byte = 2'd1;
            default:                    last_byte = 2'd3;
        endcase
    endfunction

    assign req      = load_enable | store_enable;
    assign last_idx = last_byte(type_q);
    assign cap_idx  = cnt_q - 2'd1;

    always_comb begin
        case (type_q)
            TYPE_LB:  ext_data = {{24{rdata_q[7]}}, rdata_q[7:0]};
            TYPE_LH:  ext_data = {{16{rdata_q[15]}}, rdata_q[15:0]};
            TYPE_LBU: ext_data = {24'd0, rdata_q[7:0]};
            TYPE_LHU: ext_data = {16'd0, rdata_q[15:0]};
            TYPE_LW:  ext_data = rdata_q;
            default:  ext_data = rdata_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        type_d      = type_q;
        data_d      = data_q;
        rd_d        = rd_q;
        rd_en_d     = rd_en_q;
        is_load_d   = is_load_q;
        rdata_d     = rdata_q;
        ram_a       = 32'd0;
        ram_dout    = 8'd0;
        ram_wr      = 1'b0;
        port_own    = 1'b0;
        stall_req   = 1'b0;
        done        = 1'b0;
        rd_data_o   = 32'd0;
        rd_addr     = 5'd0;
        rd_enable_o = 1'b0;

        case (state_q)
            StIdle: begin
                // Gated by reset so every output reads 0 while reset is held.
                stall_req = req & rst;
                if (req && port_gnt) begin
                    addr_d  = mem_addr;
                    type_d  = load_store_type;
                    data_d  = store_data;
                    rd_d    = rd_in;
                    cnt_d   = 2'd0;
                    rdata_d = 32'd0;
                    if (load_store_type > TYPE_SW) begin
                        is_load_d = 1'b0;
                        rd_en_d   = 1'b0;
                        state_d   = StDone;
                    end else begin
                        is_load_d = load_enable;
                        rd_en_d   = rd_enable_in;
                        state_d   = StAccess;
                    end
                end
            end
            StAccess: begin
                ram_a     = addr_q + {30'd0, cnt_q};
                port_own  = 1'b1;
                stall_req = 1'b1;
                if (!is_load_q) begin
                    ram_wr   = 1'b1;
                    ram_dout = data_q[{cnt_q, 3'b000} +: 8];
                end else if (cnt_q != 2'd0) begin
                    // RAM read data lags the address by one cycle.
                    rdata_d[{cap_idx, 3'b000} +: 8] = ram_din;
                end
                if (cnt_q == last_idx) begin
                    state_d = is_load_q ? StLast : StDone;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StLast: begin
                port_own  = 1'b1;
                stall_req = 1'b1;
                rdata_d[{cnt_q, 3'b000} +: 8] = ram_din;
                state_d   = StDone;
            end
            StDone: begin
                done = 1'b1;
                if (is_load_q) begin
                    rd_data_o   = ext_data;
                    rd_addr     = rd_q;
                    rd_enable_o = rd_en_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= 2'd0;
            addr_q    <= 32'd0;
            type_q    <= 4'd0;
            data_q    <= 32'd0;
            rd_q      <= 5'd0;
            rd_en_q   <= 1'b0;
            is_load_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            type_q    <= type_d;
            data_q    <= data_d;
            rd_q      <= rd_d;
            rd_en_q   <= rd_en_d;
            is_load_q <= is_load_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomised bench for mem_access: a byte RAM model feeds the DUT, and a reference
// memory plus arithmetic load/extend rules predict results, latency and RAM writes.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_enable, store_enable;
    logic [31:0] mem_addr;
    logic [3:0]  load_store_type;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        rd_enable_in;
    logic        port_gnt;
    logic [7:0]  ram_din;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_wr, port_own, stall_req, done;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_addr;
    logic        rd_enable_o;

    int n_checks = 0;
    int n_errs   = 0;
    int wr_cnt   = 0;

    // RAM model and reference memory, indexed by the low 16 address bits.
    logic [7:0] tb_mem  [65536];
    logic [7:0] ref_mem [65536];

    mem_access dut (
        .clk(clk), .rst(rst_n), .load_enable(load_enable), .store_enable(store_enable),
        .mem_addr(mem_addr), .load_store_type(load_store_type), .store_data(store_data),
        .rd_in(rd_in), .rd_enable_in(rd_enable_in), .port_gnt(port_gnt), .ram_din(ram_din),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .port_own(port_own),
        .stall_req(stall_req), .done(done), .rd_data_o(rd_data_o), .rd_addr(rd_addr),
        .rd_enable_o(rd_enable_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr) begin
            tb_mem[ram_a[15:0]] <= ram_dout;
            wr_cnt <= wr_cnt + 1;
        end
        ram_din <= tb_mem[ram_a[15:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [3:0] ty);
        if (ty == 4'd0 || ty == 4'd3 || ty == 4'd5) return 1;
        if (ty == 4'd1 || ty == 4'd4 || ty == 4'd6) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] ty, input logic [31:0] a);
        logic [31:0] v = 32'd0;
        logic [31:0] p;
        for (int k = 0; k < nbytes(ty); k++) begin
            p = a + 32'(k);
            v = v | (32'(ref_mem[p[15:0]]) << (8 * k));
        end
        if (ty == 4'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (ty == 4'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        tb_mem[a[15:0]]  = b;
        ref_mem[a[15:0]] = b;
    endtask

    task automatic do_op(input logic le, input logic se, input logic [3:0] ty,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                         input logic rde, input int gnt_delay);
        int          n, exp_lat, exp_wr, lat, w0;
        logic        undef, is_ld, got, own_ok, stall_ok;
        logic [31:0] exp_val, p;
        n       = nbytes(ty);
        undef   = (ty > 4'd7);
        is_ld   = le && !undef;
        exp_lat = undef ? 1 : (le ? n + 2 : n + 1);
        exp_wr  = (!le && !undef) ? n : 0;
        exp_val = is_ld ? ref_load(ty, a) : 32'd0;
        if (exp_wr != 0) begin
            for (int k = 0; k < n; k++) begin
                p = a + 32'(k);
                ref_mem[p[15:0]] = 8'(d >> (8 * k));
            end
        end
        @(negedge clk);
        load_enable = le; store_enable = se; load_store_type = ty; mem_addr = a;
        store_data = d; rd_in = rd; rd_enable_in = rde; port_gnt = 1'b0;
        for (int i = 0; i < gnt_delay; i++) begin
            #1;
            check_eq("wait_stall", 32'(stall_req), 32'd1);
            check_eq("wait_wr_own", {30'd0, ram_wr, port_own}, 32'd0);
            @(negedge clk);
        end
        port_gnt = 1'b1;
        #1 check_eq("accept_stall", 32'(stall_req), 32'd1);
        w0 = wr_cnt;
        @(posedge clk); #1;
        load_enable = 1'b0; store_enable = 1'b0; port_gnt = 1'($urandom);
        got = 1'b0; lat = 0; own_ok = 1'b1; stall_ok = 1'b1;
        for (int c = 1; c <= 20 && !got; c++) begin
            if (done) begin
                got = 1'b1; lat = c;
            end else begin
                if (!stall_req) stall_ok = 1'b0;
                if (!port_own)  own_ok = 1'b0;
                @(posedge clk); #1;
                port_gnt = 1'($urandom);
            end
        end
        if (!got) begin
            check_eq("done_timeout", 32'd0, 32'd1);
        end else begin
            check_eq("latency", 32'(lat), 32'(exp_lat));
            check_eq("busy_stall_own", {30'd0, stall_ok, own_ok}, 32'd3);
            check_eq("done_stall", 32'(stall_req), 32'd0);
            check_eq("rd_data", rd_data_o, exp_val);
            check_eq("rd_enable", 32'(rd_enable_o), is_ld ? 32'(rde) : 32'd0);
            if (is_ld) check_eq("rd_addr", 32'(rd_addr), 32'(rd));
            check_eq("wr_count", 32'(wr_cnt - w0), 32'(exp_wr));
            for (int k = 0; k < exp_wr; k++) begin
                p = a + 32'(k);
                check_eq("ram_byte", 32'(tb_mem[p[15:0]]), 32'(ref_mem[p[15:0]]));
            end
        end
        @(posedge clk); #1;
        check_eq("post_done_idle", {26'd0, done, rd_enable_o, 4'd0} | rd_data_o, 32'd0);
        port_gnt = 1'b1;
    endtask

    initial begin
        logic [3:0]  ty;
        logic [31:0] a;
        logic        le;
        for (int i = 0; i < 65536; i++) begin
            tb_mem[i] = 8'd0; ref_mem[i] = 8'd0;
        end
        rst_n = 1'b0; load_enable = 1'b0; store_enable = 1'b0; mem_addr = 32'd0;
        load_store_type = 4'd0; store_data = 32'd0; rd_in = 5'd0; rd_enable_in = 1'b0;
        port_gnt = 1'b1;
        #12;
        check_eq("reset_outs", {ram_a[30:0] | rd_data_o[30:0], ram_wr}, 32'd0);
        check_eq("reset_flags", {24'd0, ram_dout} | {27'd0, rd_addr} |
                 {28'd0, port_own, stall_req, done, rd_enable_o}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        poke(32'h100, 8'h80); poke(32'h101, 8'h11); poke(32'h102, 8'h22); poke(32'h103, 8'hF3);
        check_eq("lw_ref_const", ref_load(4'd2, 32'h100), 32'hF322_1180);
        do_op(1, 0, 4'd2, 32'h100, 32'h0, 5'd5, 1'b1, 0);
        do_op(1, 0, 4'd0, 32'h100, 32'h0, 5'd6, 1'b1, 0);
        do_op(1, 0, 4'd3, 32'h100, 32'h0, 5'd7, 1'b1, 0);
        do_op(1, 0, 4'd1, 32'h102, 32'h0, 5'd8, 1'b1, 0);
        do_op(1, 0, 4'd4, 32'h102, 32'h0, 5'd9, 1'b0, 0);
        do_op(0, 1, 4'd7, 32'h200, 32'hDEAD_BEEF, 5'd1, 1'b1, 0);
        do_op(1, 0, 4'd2, 32'h200, 32'h0, 5'd2, 1'b1, 0);
        do_op(0, 1, 4'd6, 32'hFFFF_FFFF, 32'h0000_1234, 5'd0, 1'b0, 0);
        check_eq("wrap_lo", 32'(tb_mem[16'hFFFF]), 32'h34);
        check_eq("wrap_hi", 32'(tb_mem[16'h0000]), 32'h12);
        do_op(0, 1, 4'd5, 32'h201, 32'h0000_0077, 5'd0, 1'b0, 0);
        do_op(1, 0, 4'd2, 32'h200, 32'h0, 5'd3, 1'b1, 0);
        do_op(1, 0, 4'd2, 32'h100, 32'h0, 5'd4, 1'b1, 3);
        do_op(1, 1, 4'd2, 32'h200, 32'h5555_5555, 5'd10, 1'b1, 0);
        do_op(1, 0, 4'd9, 32'h100, 32'h0, 5'd11, 1'b1, 0);

        // Reset during byte 2 of a word store.
        poke(32'h300, 8'h11); poke(32'h301, 8'h22); poke(32'h302, 8'h33); poke(32'h303, 8'h44);
        @(negedge clk);
        store_enable = 1'b1; load_store_type = 4'd7; mem_addr = 32'h300;
        store_data = 32'hAABB_CCDD; port_gnt = 1'b1;
        @(posedge clk); #1 store_enable = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("rst_byte2_addr", ram_a, 32'h302);
        load_enable = 1'b1; rst_n = 1'b0;
        #1;
        check_eq("rst_mid_outs", {ram_a[30:0] | rd_data_o[30:0], ram_wr}, 32'd0);
        check_eq("rst_mid_flags", {24'd0, ram_dout} | {27'd0, rd_addr} |
                 {28'd0, port_own, stall_req, done, rd_enable_o}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); load_enable = 1'b0; rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_kept_b0", 32'(tb_mem[16'h300]), 32'hDD);
        check_eq("rst_kept_b1", 32'(tb_mem[16'h301]), 32'hCC);
        check_eq("rst_no_b3", 32'(tb_mem[16'h303]), 32'h44);
        ref_mem[16'h300] = 8'hDD; ref_mem[16'h301] = 8'hCC; ref_mem[16'h302] = tb_mem[16'h302];

        for (int i = 0; i < 40; i++) begin
            ty = ($urandom_range(0, 9) == 0) ? 4'(8 + $urandom_range(0, 7))
                                              : 4'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 7))
                                              : 32'h1800 + 32'($urandom_range(0, 15));
            le = (ty > 4'd7) ? 1'($urandom) : (ty < 4'd5);
            do_op(le, !le, ty, a, $urandom, 5'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
